ycbcr2rgb: RTL and testbench

YCBCR2RGB -- requirements
Module: ycbcr2rgb

---
 rtl/ycbcr2rgb_if.sv | 9 +
 rtl/ycbcr2rgb.sv | 57 +++++
 tb/tb_ycbcr2rgb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ycbcr2rgb_if.sv
// ycbcr2rgb_if: YCbCr pixel/timing in and RGB pixel/timing out for the colour-space converter.
interface ycbcr2rgb_if;
    logic [7:0] y, cb, cr;
    logic in_hsync, in_vsync, in_en;
    logic [7:0] r, g, b;
    logic out_hsync, out_vsync, out_en;
    modport master(output y, cb, cr, in_hsync, in_vsync, in_en, input r, g, b, out_hsync, out_vsync, out_en);
    modport slave(input y, cb, cr, in_hsync, in_vsync, in_en, output r, g, b, out_hsync, out_vsync, out_en);
endinterface

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: 4-stage BT.601 limited-range YCbCr to full-range RGB with rounding and clamping.
module ycbcr2rgb #(
    parameter int K_Y   = 298,
    parameter int K_RCR = 409,
    parameter int K_GCB = 100,
    parameter int K_GCR = 208,
    parameter int K_BCB = 516
) (
    input logic clk,
    input logic rst,
    ycbcr2rgb_if.slave v
);
    localparam logic signed [11:0] k_y   = 12'(K_Y);
    localparam logic signed [11:0] k_rcr = 12'(K_RCR);
    localparam logic signed [11:0] k_gcb = 12'(K_GCB);
    localparam logic signed [11:0] k_gcr = 12'(K_GCR);
    localparam logic signed [11:0] k_bcb = 12'(K_BCB);
    logic signed [9:0] d_y, d_cb, d_cr;
    logic signed [19:0] p_y, p_rcr, p_gcb, p_gcr, p_bcb;
    logic signed [19:0] s_r, s_g, s_b;
    logic [2:0] t1, t2, t3;
    // (s + 128) >> 8: bit 20 is the sign, bits 19:16 nonzero means the result exceeds 255
    function automatic logic [7:0] sat(input logic signed [19:0] s);
        logic [20:0] t;
        t = {s[19], s} + 21'd128;
        return t[20] ? 8'd0 : |t[19:16] ? 8'hff : t[15:8];
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            {d_y, d_cb, d_cr} <= '0;
            {p_y, p_rcr, p_gcb, p_gcr, p_bcb} <= '0;
            {s_r, s_g, s_b} <= '0;
            {t1, t2, t3} <= '0;
            {v.r, v.g, v.b} <= '0;
            {v.out_hsync, v.out_vsync, v.out_en} <= '0;
        end else begin
            d_y <= $signed({2'b0, v.y}) - 10'sd16;
            d_cb <= $signed({2'b0, v.cb}) - 10'sd128;
            d_cr <= $signed({2'b0, v.cr}) - 10'sd128;
            p_y <= 20'(k_y * d_y);
            p_rcr <= 20'(k_rcr * d_cr);
            p_gcb <= 20'(k_gcb * d_cb);
            p_gcr <= 20'(k_gcr * d_cr);
            p_bcb <= 20'(k_bcb * d_cb);
            s_r <= p_y + p_rcr;
            s_g <= p_y - p_gcb - p_gcr;
            s_b <= p_y + p_bcb;
            t1 <= {v.in_hsync, v.in_vsync, v.in_en};
            t2 <= t1;
            t3 <= t2;
            {v.out_hsync, v.out_vsync, v.out_en} <= t3;
            v.r <= t3[0] ? sat(s_r) : 8'd0;
            v.g <= t3[0] ? sat(s_g) : 8'd0;
            v.b <= t3[0] ? sat(s_b) : 8'd0;
        end
    end
endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb: vector table, random stream, sync alignment and mid-stream reset against a cycle scoreboard.
module tb_ycbcr2rgb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ycbcr2rgb_if v();
    ycbcr2rgb dut(.clk(clk), .rst(rst), .v(v));
    typedef struct {logic [7:0] r, g, b; logic hs, vs, en;} exp_t;
    typedef struct {logic [7:0] y, cb, cr, r, g, b;} vec_t;
    exp_t q[$];
    exp_t pend = '{default: '0};
    exp_t zero = '{default: '0};
    exp_t e0;
    int n_cmp = 0, n_bad = 0, cyc = 0, hs_cyc = 0, seen_cyc = -1, en_cnt = 0;
    logic [7:0] seen_r, seen_g, seen_b;
    bit chk = 0;
    vec_t tab[7];

    function automatic logic [7:0] ch(input int s);
        int t;
        t = s + 128;
        if (t < 0) return 8'd0;
        if (t / 256 > 255) return 8'd255;
        return 8'(t / 256);
    endfunction

    function automatic exp_t model(input int y, input int cb, input int cr, input logic hs, input logic vs, input logic en);
        exp_t e;
        int yy;
        yy = 298 * (y - 16);
        e.hs = hs; e.vs = vs; e.en = en;
        e.r = en ? ch(yy + 409 * (cr - 128)) : 8'd0;
        e.g = en ? ch(yy - 100 * (cb - 128) - 208 * (cr - 128)) : 8'd0;
        e.b = en ? ch(yy + 516 * (cb - 128)) : 8'd0;
        return e;
    endfunction

    task automatic drive(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic hs, input logic vs, input logic en, input logic rs, input exp_t e);
        @(negedge clk);
        v.y = y; v.cb = cb; v.cr = cr;
        v.in_hsync = hs; v.in_vsync = vs; v.in_en = en;
        rst = rs;
        pend = e;
    endtask

    task automatic px(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                      input logic hs, input logic vs, input logic en);
        drive(y, cb, cr, hs, vs, en, 1'b0, model(int'(y), int'(cb), int'(cr), hs, vs, en));
    endtask

    // the queue mirrors the four pipeline stages; q[0] is what r/g/b must show now
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            repeat (4) q.push_back(zero);
            en_cnt = 0;
        end else begin
            q.push_back(pend);
            void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (v.out_en) en_cnt++;
        if (v.out_hsync && seen_cyc < 0) begin
            seen_cyc = cyc;
            seen_r = v.r; seen_g = v.g; seen_b = v.b;
        end
        if (chk) begin
            n_cmp++;
            if (v.r !== q[0].r || v.g !== q[0].g || v.b !== q[0].b ||
                v.out_hsync !== q[0].hs || v.out_vsync !== q[0].vs || v.out_en !== q[0].en) begin
                n_bad++;
                $display("FAIL pixel cyc=%0d got rgb=%0d,%0d,%0d hs/vs/en=%b%b%b want rgb=%0d,%0d,%0d hs/vs/en=%b%b%b",
                         cyc, v.r, v.g, v.b, v.out_hsync, v.out_vsync, v.out_en,
                         q[0].r, q[0].g, q[0].b, q[0].hs, q[0].vs, q[0].en);
            end
        end
    end

    initial begin
        tab = '{'{8'd16, 8'd128, 8'd128, 8'd0, 8'd0, 8'd0},
                '{8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255},
                '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255},
                '{8'd81, 8'd90, 8'd240, 8'd255, 8'd0, 8'd0},
                '{8'd126, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128},
                '{8'd16, 8'd128, 8'd255, 8'd203, 8'd0, 8'd0},
                '{8'd16, 8'd255, 8'd128, 8'd0, 8'd0, 8'd255}};
        v.y = 8'd0; v.cb = 8'd0; v.cr = 8'd0;
        v.in_hsync = 1'b0; v.in_vsync = 1'b0; v.in_en = 1'b0;
        repeat (2) @(negedge clk);
        chk = 1;
        n_cmp++;
        if ({v.r, v.g, v.b, v.out_hsync, v.out_vsync, v.out_en} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_state got %h want 0", {v.r, v.g, v.b, v.out_hsync, v.out_vsync, v.out_en});
        end
        for (int i = 0; i < 7; i++)
            drive(tab[i].y, tab[i].cb, tab[i].cr, 1'b0, 1'b0, 1'b1, 1'b0,
                  '{r: tab[i].r, g: tab[i].g, b: tab[i].b, hs: 1'b0, vs: 1'b0, en: 1'b1});
        repeat (3) px(8'd200, 8'd50, 8'd60, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++)
            px(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        repeat (5) px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        seen_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            px(8'(40 + 25 * i), 8'(30 * i), 8'(250 - 20 * i), i == 0, 1'b0, 1'b1);
            if (i == 0) begin
                hs_cyc = cyc;
                e0 = pend;
            end
        end
        repeat (6) px(8'd90, 8'd90, 8'd90, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (seen_cyc != hs_cyc + 4 || seen_r !== e0.r || seen_g !== e0.g || seen_b !== e0.b) begin
            n_bad++;
            $display("FAIL hsync_align got cyc=%0d rgb=%0d,%0d,%0d want cyc=%0d rgb=%0d,%0d,%0d",
                     seen_cyc, seen_r, seen_g, seen_b, hs_cyc + 4, e0.r, e0.g, e0.b);
        end
        for (int i = 0; i < 4; i++) px(8'(60 + 30 * i), 8'd100, 8'd150, 1'b0, 1'b0, 1'b1);
        drive(8'd180, 8'd20, 8'd220, 1'b1, 1'b1, 1'b1, 1'b1, zero);
        px(8'd100, 8'd140, 8'd110, 1'b0, 1'b0, 1'b1);
        px(8'd220, 8'd60, 8'd200, 1'b0, 1'b1, 1'b1);
        repeat (8) px(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (en_cnt != 2) begin
            n_bad++;
            $display("FAIL post_reset_pixels got %0d want 2", en_cnt);
        end
        chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
